// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Round-robin arbiter that shares one sdram_core control port
//               between NUM_PORTS requesters. It registers the winning
//               request, issues it to the core and tracks the single
//               outstanding transaction. Completions are routed back to the
//               owning port. A watchdog aborts transactions that the core
//               never completes.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_W     = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    // requester side
    input  logic [NUM_PORTS-1:0]            p_rd,
    input  logic [NUM_PORTS*MASK_W-1:0]     p_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]            p_ack,
    output logic [NUM_PORTS-1:0]            p_rvalid,
    output logic [NUM_PORTS-1:0]            p_wvalid,
    output logic [NUM_PORTS-1:0]            p_error,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    // core control port
    output logic                            m_rd,
    output logic [MASK_W-1:0]               m_wr,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    input  logic                            m_rdy,
    input  logic                            m_rvalid,
    input  logic                            m_wvalid,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide so
    // the declaration stays legal.
    localparam int c_WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_WD_W-1:0]  c_WD_LIMIT  = c_WD_W'(TIMEOUT);
    localparam bit                 c_WD_EN     = (TIMEOUT != 0);
    localparam logic [c_PTR_W-1:0] c_LAST_PORT = c_PTR_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] c_ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for any requester
        S_ISSUE = 2'd1,   // presenting the captured request to the core
        S_WAIT  = 2'd2    // request accepted, waiting for completion
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [c_PTR_W-1:0]     r_owner;
    logic [c_WD_W-1:0]      r_wd_cnt;
    logic                   r_m_rd;
    logic [MASK_W-1:0]      r_m_wr;
    logic [ADDR_WIDTH-1:0]  r_m_addr;
    logic [DATA_WIDTH-1:0]  r_m_wdata;
    logic [NUM_PORTS-1:0]   r_ack;

    logic [NUM_PORTS-1:0]   w_req;
    logic [c_PTR_W-1:0]     w_grant;
    logic                   w_grant_vld;
    int                     w_idx;
    logic [NUM_PORTS-1:0]   w_grant_oh;
    logic [NUM_PORTS-1:0]   w_owner_oh;

    logic                   w_sel_rd;
    logic [MASK_W-1:0]      w_sel_wr;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    logic                   w_in_wait;
    logic                   w_complete;
    logic                   w_done_ok;
    logic                   w_expire;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_release;

    // ------------------------------------------------------------------------
    // Per-port request detection: a port asks for service when it raises its
    // read line or any byte-write strobe.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
        assign w_req[gi] = p_rd[gi] | (|p_wr[gi*MASK_W +: MASK_W]);
    end

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to (at or after) r_rr_ptr is the last one written and wins.
    always_comb begin
        w_grant     = r_rr_ptr;
        w_grant_vld = 1'b0;
        w_idx       = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (w_req[w_idx]) begin
                w_grant     = c_PTR_W'(w_idx);
                w_grant_vld = 1'b1;
            end
        end
    end

    // Fields of the winning port; a combined read+write is treated as a read.
    assign w_sel_rd    = p_rd[w_grant];
    assign w_sel_wr    = p_rd[w_grant] ? '0
                                       : p_wr[int'(w_grant)*MASK_W +: MASK_W];
    assign w_sel_addr  = p_addr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = p_wdata[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];

    assign w_grant_oh  = c_ONE_HOT0 << w_grant;
    assign w_owner_oh  = c_ONE_HOT0 << r_owner;

    // ------------------------------------------------------------------------
    // Completion and watchdog conditions (meaningful only in S_WAIT)
    // ------------------------------------------------------------------------
    assign w_in_wait  = (r_state == S_WAIT);
    assign w_done_ok  = m_rvalid | m_wvalid;
    assign w_complete = w_done_ok | m_error;
    // A real completion in the same cycle as the limit takes precedence.
    assign w_expire   = c_WD_EN && (r_wd_cnt == c_WD_LIMIT) && !w_done_ok;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the single-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_rdy && (r_m_rd || (|r_m_wr))) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_complete || w_expire) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture into the core-facing registers; the command strobes
    // are dropped on acceptance so the core never sees the request twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= '0;
            r_ack     <= '0;
            r_m_rd    <= 1'b0;
            r_m_wr    <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_ack <= '0;
            if (w_capture) begin
                r_owner   <= w_grant;
                r_ack     <= w_grant_oh;
                r_m_rd    <= w_sel_rd;
                r_m_wr    <= w_sel_wr;
                r_m_addr  <= w_sel_addr;
                r_m_wdata <= w_sel_wdata;
            end
            if (w_accept) begin
                r_m_rd <= 1'b0;
                r_m_wr <= '0;
            end
        end
    end

    // Watchdog counter: restarts on acceptance, counts while waiting and
    // saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (w_accept) begin
            r_wd_cnt <= '0;
        end else if (w_in_wait && (r_wd_cnt != c_WD_LIMIT)) begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    // Round-robin pointer moves past the owner whenever a transaction ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_release) begin
            r_rr_ptr <= (r_owner == c_LAST_PORT) ? '0 : r_owner + c_PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Completion routing is combinational so the requester sees the
    // result in the same cycle the core reports it; anything arriving outside
    // S_WAIT has no owner and is dropped.
    // ------------------------------------------------------------------------
    assign p_ack    = r_ack;
    assign p_rvalid = (w_in_wait && m_rvalid) ? w_owner_oh : '0;
    assign p_wvalid = (w_in_wait && m_wvalid) ? w_owner_oh : '0;
    assign p_error  = (w_in_wait && (m_error || w_expire)) ? w_owner_oh : '0;
    assign p_rdata  = (w_in_wait && m_rvalid) ? m_rdata : '0;

    assign m_rd     = r_m_rd;
    assign m_wr     = r_m_wr;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Self-checking bench for sdram_port_arbiter. A transaction
//               level model predicts every output each cycle; directed
//               scenarios add literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MW = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   p_rd = '0;
    logic [NP*MW-1:0] p_wr = '0;
    logic [NP*AW-1:0] p_addr = '0;
    logic [NP*DW-1:0] p_wdata = '0;
    logic [NP-1:0]   p_ack, p_rvalid, p_wvalid, p_error;
    logic [DW-1:0]   p_rdata;
    logic            m_rd;
    logic [MW-1:0]   m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_rdy = 1'b0;
    logic            m_rvalid = 1'b0;
    logic            m_wvalid = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_error = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MASK_W    (MW),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_rd    (p_rd),
        .p_wr    (p_wr),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_ack   (p_ack),
        .p_rvalid(p_rvalid),
        .p_wvalid(p_wvalid),
        .p_error (p_error),
        .p_rdata (p_rdata),
        .m_rd    (m_rd),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdy   (m_rdy),
        .m_rvalid(m_rvalid),
        .m_wvalid(m_wvalid),
        .m_rdata (m_rdata),
        .m_error (m_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change only just after a rising edge.
    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic rd, input logic [MW-1:0] wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_rd[i]             = rd;
        p_wr[i*MW +: MW]    = wr;
        p_addr[i*AW +: AW]  = a;
        p_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int port);
        bit got = 0;
        int k = 0;
        while (!got && k < 20) begin
            do_cycle();
            k++;
            if (p_ack[port]) got = 1;
        end
        chk($sformatf("ack_port%0d_seen", port), 32'(got), 32'd1);
    endtask

    task automatic wait_any_ack(output int idx);
        int k = 0;
        idx = -1;
        while (idx < 0 && k < 20) begin
            do_cycle();
            k++;
            for (int i = 0; i < NP; i++) if (p_ack[i]) idx = i;
        end
        chk("any_ack_seen", 32'(idx >= 0), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one outstanding job, fair pick by distance from the
    // next-start port, completions routed to whoever holds the job.
    // ------------------------------------------------------------------------
    bit            busy = 0;      // a job is held by some port
    bit            sent = 0;      // the core has taken the job
    bit            ack_due = 0;
    int            who = 0;
    int            start = 0;
    int            age = 0;
    logic          cap_rd = 1'b0;
    logic [MW-1:0] cap_wr = '0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;

    always @(negedge clk) begin
        logic [NP-1:0] e_ack, e_rv, e_wv, e_er;
        logic [DW-1:0] e_rdata;
        logic          e_mrd;
        logic [MW-1:0] e_mwr;
        bit            waiting, fin, expire;
        int            best, bestd, d;
        if (rst) begin
            e_ack = '0; e_rv = '0; e_wv = '0; e_er = '0; e_rdata = '0;
            e_mrd = 1'b0; e_mwr = '0;
            busy = 0; sent = 0; ack_due = 0; who = 0; start = 0; age = 0;
            cap_rd = 1'b0; cap_wr = '0; cap_addr = '0; cap_wdata = '0;
            waiting = 0; fin = 0; expire = 0;
        end else begin
            waiting = busy && sent;
            fin     = m_rvalid || m_wvalid || m_error;
            expire  = (age == TO) && !(m_rvalid || m_wvalid);
            e_ack   = ack_due ? NP'(1) << who : '0;
            e_mrd   = (busy && !sent) ? cap_rd : 1'b0;
            e_mwr   = (busy && !sent) ? cap_wr : '0;
            e_rv    = (waiting && m_rvalid) ? NP'(1) << who : '0;
            e_wv    = (waiting && m_wvalid) ? NP'(1) << who : '0;
            e_er    = (waiting && (m_error || expire)) ? NP'(1) << who : '0;
            e_rdata = (waiting && m_rvalid) ? m_rdata : '0;
        end
        chk("model_p_ack",    32'(p_ack),    32'(e_ack));
        chk("model_p_rvalid", 32'(p_rvalid), 32'(e_rv));
        chk("model_p_wvalid", 32'(p_wvalid), 32'(e_wv));
        chk("model_p_error",  32'(p_error),  32'(e_er));
        chk("model_p_rdata",  32'(p_rdata),  32'(e_rdata));
        chk("model_m_rd",     32'(m_rd),     32'(e_mrd));
        chk("model_m_wr",     32'(m_wr),     32'(e_mwr));
        chk("model_m_addr",   32'(m_addr),   32'(cap_addr));
        chk("model_m_wdata",  32'(m_wdata),  32'(cap_wdata));
        if (!rst) begin
            ack_due = 0;
            if (!busy) begin
                best = -1; bestd = NP;
                for (int i = 0; i < NP; i++) begin
                    if (p_rd[i] || (p_wr[i*MW +: MW] != '0)) begin
                        d = (i - start + NP) % NP;
                        if (d < bestd) begin bestd = d; best = i; end
                    end
                end
                if (best >= 0) begin
                    busy = 1; sent = 0; ack_due = 1; who = best;
                    cap_rd    = p_rd[best];
                    cap_wr    = p_rd[best] ? '0 : p_wr[best*MW +: MW];
                    cap_addr  = p_addr[best*AW +: AW];
                    cap_wdata = p_wdata[best*DW +: DW];
                end
            end else if (!sent) begin
                if (m_rdy) begin sent = 1; age = 0; end
            end else if (fin || expire) begin
                busy = 0; sent = 0; start = (who + 1) % NP;
            end else if (age < TO) begin
                age++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int idx;
        int k;
        repeat (3) do_cycle();
        rst = 1'b0;
        m_rdy = 1'b1;

        // Single read from port 1.
        set_port(1, 1'b1, 2'b00, 24'h000123, 16'h0000);
        wait_ack(1);
        chk("t1_m_addr", 32'(m_addr), 32'h000123);
        chk("t1_m_rd", 32'(m_rd), 32'd1);
        p_rd[1] = 1'b0;
        do_cycle();
        m_rvalid = 1'b1; m_rdata = 16'hBEEF;
        #1;
        chk("t1_p_rvalid", 32'(p_rvalid), 32'h2);
        chk("t1_p_rdata", 32'(p_rdata), 32'hBEEF);
        chk("t1_p_error", 32'(p_error), 32'h0);
        do_cycle();
        m_rvalid = 1'b0; m_rdata = '0;

        // All ports request continuously from a fresh pointer.
        rst = 1'b1;
        do_cycle(); do_cycle();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 2'b00, 24'(32'h1000 * (i + 1)), 16'h0);
        for (int n = 0; n < 5; n++) begin
            wait_any_ack(idx);
            order.push_back(idx);
            do_cycle();
            m_rvalid = 1'b1; m_rdata = 16'(16'hA000 + n);
            do_cycle();
            m_rvalid = 1'b0;
        end
        p_rd = '0;
        for (int n = 0; n < 5; n++)
            chk($sformatf("t2_grant%0d", n), (n < order.size()) ? 32'(order[n]) : 32'hFFFF_FFFF,
                32'(exp_order[n]));

        // Port 2 write while the core is busy refreshing.
        m_rdy = 1'b0;
        set_port(2, 1'b0, 2'b10, 24'h000200, 16'h55AA);
        wait_ack(2);
        p_wr = '0;
        chk("t3_m_wdata", 32'(m_wdata), 32'h55AA);
        for (int n = 0; n < 20; n++) begin
            chk("t3_m_wr_held", 32'(m_wr), 32'h2);
            do_cycle();
        end
        m_rdy = 1'b1;
        do_cycle();
        chk("t3_m_wr_cleared", 32'(m_wr), 32'h0);
        m_wvalid = 1'b1;
        #1;
        chk("t3_p_wvalid", 32'(p_wvalid), 32'h4);
        do_cycle();
        m_wvalid = 1'b0;

        // Watchdog: port 3 read never completes, port 0 waits behind it.
        set_port(3, 1'b1, 2'b00, 24'h000300, 16'h0);
        set_port(0, 1'b1, 2'b00, 24'h000000, 16'h0);
        wait_ack(3);
        p_rd[3] = 1'b0;
        do_cycle();
        k = 0;
        while (p_error == '0 && k < 30) begin
            do_cycle();
            k++;
        end
        chk("t4_wd_latency", 32'(k), 32'd8);
        chk("t4_p_error", 32'(p_error), 32'h8);
        wait_ack(0);
        p_rd[0] = 1'b0;
        do_cycle();
        m_rvalid = 1'b1; m_rdata = 16'h0BAD;
        do_cycle();
        m_rvalid = 1'b0;

        // Completion on the very cycle the watchdog expires; rd+wr is a read.
        set_port(1, 1'b1, 2'b11, 24'h000111, 16'h1111);
        wait_ack(1);
        chk("t5_m_wr_forced0", 32'(m_wr), 32'h0);
        chk("t5_m_rd", 32'(m_rd), 32'd1);
        p_rd = '0; p_wr = '0;
        do_cycle();
        repeat (TO) do_cycle();
        m_rvalid = 1'b1; m_rdata = 16'hCAFE;
        #1;
        chk("t5_p_rvalid", 32'(p_rvalid), 32'h2);
        chk("t5_p_error", 32'(p_error), 32'h0);
        do_cycle();
        m_rvalid = 1'b0;

        // Reset while waiting; a late core response must go nowhere.
        set_port(0, 1'b1, 2'b00, 24'h000042, 16'h0);
        wait_ack(0);
        p_rd[0] = 1'b0;
        do_cycle();
        rst = 1'b1;
        do_cycle(); do_cycle();
        rst = 1'b0;
        m_rvalid = 1'b1; m_rdata = 16'h1234;
        #1;
        chk("t6_stray_rvalid", 32'(p_rvalid), 32'h0);
        chk("t6_stray_rdata", 32'(p_rdata), 32'h0);
        do_cycle();
        m_rvalid = 1'b0; m_wvalid = 1'b1;
        do_cycle();
        m_wvalid = 1'b0;
        set_port(2, 1'b1, 2'b00, 24'h000222, 16'h0);
        wait_ack(2);
        chk("t6_m_addr", 32'(m_addr), 32'h000222);
        p_rd[2] = 1'b0;
        do_cycle();
        m_rvalid = 1'b1; m_rdata = 16'h0F0F;
        #1;
        chk("t6_p_rvalid", 32'(p_rvalid), 32'h4);
        chk("t6_p_rdata", 32'(p_rdata), 32'h0F0F);
        do_cycle();
        m_rvalid = 1'b0;
        repeat (3) do_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
